// File: rtl/axibram_write.sv
// AXI3 write-channel slave for a GP0 window. AW bursts are queued, expanded into single-word
// writes on a registered block-RAM write port, and one B response is returned per burst.
//
// Ports:
//   aclk / arst          clock, synchronous active-high reset
//   aw*                  AW channel (awsize ignored, 32-bit beats assumed)
//   w*                   W channel (wid ignored, wlast not used for framing)
//   b*                   B channel (bresp always OKAY)
//   pre_awaddr           word address at the head of the AW queue, for external decode
//   start_burst          one-cycle pulse when a burst is popped from the AW queue
//   dev_ready            combinational ready from the device selected at start_burst
//   bram_*               registered write port to the memory, clocked by bram_wclk
module axibram_write #(
  parameter int unsigned ADDRESS_BITS = 10
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic [31:0]             awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [11:0]             awid,
  input  logic [3:0]              awlen,
  input  logic [1:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  input  logic [11:0]             wid,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [11:0]             bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ADDRESS_BITS-1:0] pre_awaddr,
  output logic                    start_burst,
  input  logic                    dev_ready,
  output logic                    bram_wclk,
  output logic [ADDRESS_BITS-1:0] bram_waddr,
  output logic                    bram_wen,
  output logic [3:0]              bram_wstb,
  output logic [31:0]             bram_wdata
);

  localparam int unsigned AW = ADDRESS_BITS;

  typedef struct packed {
    logic [11:0]   id;
    logic [1:0]    burst;
    logic [3:0]    len;
    logic [AW-1:0] addr;
  } aw_entry_t;

  logic unused_ok;
  assign unused_ok = ^{awsize, wid, wlast, awaddr[31:AW+2], awaddr[1:0]};

  // AW queue
  aw_entry_t aw_mem_q [4];
  logic [1:0] aw_wptr_q, aw_rptr_q;
  logic [2:0] aw_cnt_q;
  logic       aw_push;
  aw_entry_t  aw_head;

  // B queue
  logic [11:0] b_mem_q [4];
  logic [1:0]  b_wptr_q, b_rptr_q;
  logic [2:0]  b_cnt_q;
  logic        b_pop;
  logic [2:0]  b_resv;

  // Burst engine
  logic          active_q, active_d;
  logic [AW-1:0] addr_q, addr_d, addr_next, wrap_mask;
  logic [3:0]    left_q, left_d;
  logic [1:0]    burst_q, burst_d;
  logic [3:0]    len_q, len_d;
  logic [11:0]   id_q, id_d;
  logic          beat, last_beat;

  // Response pushed one edge after the last beat, alongside its bram_wen
  logic          bpush_q;
  logic [11:0]   bpush_id_q;

  assign aw_head    = aw_mem_q[aw_rptr_q];
  assign awready    = (aw_cnt_q < 3'd2);
  assign aw_push    = awvalid && awready;
  assign pre_awaddr = aw_head.addr;

  assign wready    = active_q && dev_ready;
  assign beat      = wready && wvalid;
  assign last_beat = beat && (left_q == 4'd0);

  // Count every response that is owed, not just those already queued, so a new burst can
  // never overrun the 4-entry B queue: queued + pending push + burst in flight.
  assign b_resv = b_cnt_q + {2'b00, bpush_q} + {2'b00, active_q};

  assign start_burst = (aw_cnt_q != 3'd0) && (b_resv <= 3'd2) && (!active_q || last_beat);

  assign bvalid    = (b_cnt_q != 3'd0);
  assign bid       = bvalid ? b_mem_q[b_rptr_q] : 12'h000;
  assign bresp     = 2'b00;
  assign b_pop     = bvalid && bready;
  assign bram_wclk = aclk;

  // WRAP keeps the bits above the len mask and lets only the masked low bits roll over.
  assign wrap_mask = {{(AW-4){1'b0}}, len_q};

  always_comb begin
    addr_next = '0;
    case (burst_q)
      2'd0:    addr_next = addr_q;
      2'd1:    addr_next = addr_q + 1'b1;
      2'd2:    addr_next = (addr_q & ~wrap_mask) | ((addr_q + 1'b1) & wrap_mask);
      default: addr_next = '0;
    endcase
  end

  always_comb begin
    active_d = active_q;
    addr_d   = addr_q;
    left_d   = left_q;
    burst_d  = burst_q;
    len_d    = len_q;
    id_d     = id_q;
    if (start_burst) begin
      active_d = 1'b1;
      addr_d   = aw_head.addr;
      left_d   = aw_head.len;
      burst_d  = aw_head.burst;
      len_d    = aw_head.len;
      id_d     = aw_head.id;
    end else if (last_beat) begin
      active_d = 1'b0;
    end else if (beat) begin
      left_d = left_q - 4'd1;
      addr_d = addr_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      aw_wptr_q <= '0;
      aw_rptr_q <= '0;
      aw_cnt_q  <= '0;
      for (int i = 0; i < 4; i++) aw_mem_q[i] <= '0;
    end else begin
      if (aw_push) begin
        aw_mem_q[aw_wptr_q] <= '{id: awid, burst: awburst, len: awlen, addr: awaddr[AW+1:2]};
        aw_wptr_q           <= aw_wptr_q + 2'd1;
      end
      if (start_burst) aw_rptr_q <= aw_rptr_q + 2'd1;
      aw_cnt_q <= aw_cnt_q + {2'b00, aw_push} - {2'b00, start_burst};
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      b_wptr_q <= '0;
      b_rptr_q <= '0;
      b_cnt_q  <= '0;
      for (int i = 0; i < 4; i++) b_mem_q[i] <= '0;
    end else begin
      if (bpush_q) begin
        b_mem_q[b_wptr_q] <= bpush_id_q;
        b_wptr_q          <= b_wptr_q + 2'd1;
      end
      if (b_pop) b_rptr_q <= b_rptr_q + 2'd1;
      b_cnt_q <= b_cnt_q + {2'b00, bpush_q} - {2'b00, b_pop};
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      active_q   <= 1'b0;
      addr_q     <= '0;
      left_q     <= '0;
      burst_q    <= '0;
      len_q      <= '0;
      id_q       <= '0;
      bpush_q    <= 1'b0;
      bpush_id_q <= '0;
      bram_wen   <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
      bram_wstb  <= '0;
    end else begin
      active_q   <= active_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      burst_q    <= burst_d;
      len_q      <= len_d;
      id_q       <= id_d;
      bpush_q    <= last_beat;
      bpush_id_q <= id_q;
      bram_wen   <= beat;
      if (beat) begin
        bram_waddr <= addr_q;
        bram_wdata <= wdata;
        bram_wstb  <= wstrb;
      end
    end
  end

endmodule

// File: tb/tb_axibram_write.sv
module tb_axibram_write;

  logic        aclk = 1'b0;
  logic        arst;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [11:0] awid;
  logic [3:0]  awlen;
  logic [1:0]  awsize;
  logic [1:0]  awburst;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [11:0] wid;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [11:0] bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [9:0]  pre_awaddr;
  logic        start_burst;
  logic        dev_ready;
  logic        bram_wclk;
  logic [9:0]  bram_waddr;
  logic        bram_wen;
  logic [3:0]  bram_wstb;
  logic [31:0] bram_wdata;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;

  axibram_write #(.ADDRESS_BITS(10)) dut (
    .aclk(aclk), .arst(arst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .pre_awaddr(pre_awaddr), .start_burst(start_burst), .dev_ready(dev_ready),
    .bram_wclk(bram_wclk), .bram_waddr(bram_waddr), .bram_wen(bram_wen),
    .bram_wstb(bram_wstb), .bram_wdata(bram_wdata)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (start_burst) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [11:0] id, input logic [3:0] len,
                         input logic [1:0] bt);
    int n;
    awaddr  = a;
    awid    = id;
    awlen   = len;
    awburst = bt;
    awvalid = 1'b1;
    n = 0;
    #1;
    while (!awready && n < 50) begin
      tick();
      n++;
    end
    chk("aw_handshake", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
  endtask

  // Single burst on an idle engine; exp_a holds the expected word address of beat i at [i*10+:10]
  task automatic run_burst(input string tag, input logic [31:0] a, input logic [11:0] id,
                           input logic [3:0] len, input logic [1:0] bt, input logic [39:0] exp_a);
    logic [31:0] d;
    int n;
    send_aw(a, id, len, bt);
    #1;
    chk({tag, "_start"}, {31'd0, start_burst}, 32'd1);
    chk({tag, "_pre_addr"}, {22'd0, pre_awaddr}, {22'd0, exp_a[9:0]});
    chk({tag, "_wready_lat0"}, {31'd0, wready}, 32'd0);
    wvalid = 1'b1;
    wstrb  = 4'hF;
    tick();
    chk({tag, "_wready_lat1"}, {31'd0, wready}, 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      d     = {8'hC0, id, 8'h00, 4'h0, i[3:0]};
      wdata = d;
      n = 0;
      while (!wready && n < 20) begin
        tick();
        n++;
      end
      tick();
      chk({tag, "_wen"}, {31'd0, bram_wen}, 32'd1);
      chk({tag, "_waddr"}, {22'd0, bram_waddr}, {22'd0, exp_a[i*10 +: 10]});
      chk({tag, "_wdata"}, bram_wdata, d);
      chk({tag, "_wstb"}, {28'd0, bram_wstb}, 32'hF);
    end
    wvalid = 1'b0;
    #1;
    chk({tag, "_bvalid_early"}, {31'd0, bvalid}, 32'd0);
    tick();
    chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    chk({tag, "_bid"}, {20'd0, bid}, {20'd0, id});
    chk({tag, "_bresp"}, {30'd0, bresp}, 32'd0);
    tick();
    chk({tag, "_bvalid_pop"}, {31'd0, bvalid}, 32'd0);
  endtask

  initial begin
    int k;
    int c;
    int n;
    int base;
    logic took;

    arst = 1'b1; awaddr = '0; awvalid = 1'b0; awid = '0; awlen = '0; awsize = 2'd2;
    awburst = '0; wdata = '0; wstrb = '0; wid = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1; dev_ready = 1'b1;
    repeat (3) tick();
    arst = 1'b0;
    #1;
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_wen", {31'd0, bram_wen}, 32'd0);
    chk("rst_start", {31'd0, start_burst}, 32'd0);
    chk("rst_bid", {20'd0, bid}, 32'd0);
    chk("rst_bresp", {30'd0, bresp}, 32'd0);
    chk("rst_waddr", {22'd0, bram_waddr}, 32'd0);
    chk("rst_wdata", bram_wdata, 32'd0);
    chk("rst_wstb", {28'd0, bram_wstb}, 32'd0);

    // INCR at word 0x10, WRAP from 0x0E inside 0x0C..0x0F, FIXED at 0x08
    run_burst("incr", 32'h40, 12'h123, 4'd3, 2'd1, {10'h13, 10'h12, 10'h11, 10'h10});
    run_burst("wrap", 32'h38, 12'h0B2, 4'd3, 2'd2, {10'h0D, 10'h0C, 10'h0F, 10'h0E});
    run_burst("fixed", 32'h20, 12'h3C4, 4'd2, 2'd0, {10'h00, 10'h08, 10'h08, 10'h08});

    // Back-to-back INCR bursts: words 0x40..0x43 then 0x80..0x83 with no gap
    bready = 1'b0;
    send_aw(32'h100, 12'd5, 4'd3, 2'd1);
    send_aw(32'h200, 12'd9, 4'd3, 2'd1);
    wvalid = 1'b1;
    wstrb  = 4'hF;
    #1;
    chk("b2b_wready", {31'd0, wready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      wdata = 32'hB2B0_0000 + i;
      tick();
      chk("b2b_wen", {31'd0, bram_wen}, 32'd1);
      chk("b2b_waddr", {22'd0, bram_waddr}, (i < 4) ? (32'h40 + i) : (32'h80 + i - 4));
      chk("b2b_wdata", bram_wdata, 32'hB2B0_0000 + i);
    end
    wvalid = 1'b0;
    tick();
    chk("b2b_bvalid", {31'd0, bvalid}, 32'd1);
    chk("b2b_bid0", {20'd0, bid}, 32'd5);
    bready = 1'b1;
    tick();
    chk("b2b_bid1", {20'd0, bid}, 32'd9);
    tick();
    chk("b2b_bempty", {31'd0, bvalid}, 32'd0);

    // dev_ready toggling 1010...: wready follows it, exactly four writes to 0xC0..0xC3
    send_aw(32'h300, 12'h0A1, 4'd3, 2'd1);
    wvalid = 1'b1;
    dev_ready = 1'b1;
    tick();
    k = 0;
    c = 0;
    while (k < 4 && c < 20) begin
      dev_ready = (c % 2 == 0);
      wdata = 32'h5A5A_0000 + k;
      wstrb = 4'b0001 << k;
      #1;
      chk("dr_wready", {31'd0, wready}, {31'd0, dev_ready});
      took = wready;
      tick();
      chk("dr_wen", {31'd0, bram_wen}, {31'd0, took});
      if (took) begin
        chk("dr_waddr", {22'd0, bram_waddr}, 32'hC0 + k);
        chk("dr_wstb", {28'd0, bram_wstb}, 32'd1 << k);
        chk("dr_wdata", bram_wdata, 32'h5A5A_0000 + k);
        k++;
      end
      c++;
    end
    chk("dr_beats", k, 32'd4);
    dev_ready = 1'b1;
    #1;
    chk("dr_no_extra", {31'd0, wready}, 32'd0);
    wvalid = 1'b0;
    tick();
    chk("dr_bvalid", {31'd0, bvalid}, 32'd1);
    chk("dr_bid", {20'd0, bid}, 32'h0A1);
    tick();

    // bready low: three single-beat bursts complete, the fourth is held back
    bready = 1'b0;
    wvalid = 1'b1;
    wstrb  = 4'hF;
    wdata  = 32'h1111_2222;
    base   = start_cnt;
    send_aw(32'h000, 12'd1, 4'd0, 2'd1);
    send_aw(32'h004, 12'd2, 4'd0, 2'd1);
    send_aw(32'h008, 12'd3, 4'd0, 2'd1);
    send_aw(32'h00C, 12'd4, 4'd0, 2'd1);
    repeat (20) tick();
    chk("bp_starts3", start_cnt - base, 32'd3);
    chk("bp_start_held", {31'd0, start_burst}, 32'd0);
    chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      n = 0;
      while (!bvalid && n < 20) begin
        tick();
        n++;
      end
      chk("bp_bid", {20'd0, bid}, j);
      tick();
    end
    wvalid = 1'b0;
    chk("bp_starts4", start_cnt - base, 32'd4);
    tick();
    chk("bp_bempty", {31'd0, bvalid}, 32'd0);

    // Reset after two beats of a four-beat burst
    send_aw(32'h40, 12'h077, 4'd3, 2'd1);
    wvalid = 1'b1;
    wdata  = 32'hDEAD_BEEF;
    tick();
    tick();
    tick();
    arst = 1'b1;
    tick();
    arst = 1'b0;
    #1;
    chk("mrst_wen", {31'd0, bram_wen}, 32'd0);
    chk("mrst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("mrst_awready", {31'd0, awready}, 32'd1);
    chk("mrst_wready", {31'd0, wready}, 32'd0);
    wvalid = 1'b0;
    run_burst("post_rst", 32'h80, 12'h055, 4'd3, 2'd1, {10'h23, 10'h22, 10'h21, 10'h20});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
